// File: rtl/pengo_hs_scheduler.sv
// Arbitrates Pengo work RAM between the Z80 and the hiscore engine, merges user and hiscore
// pause into core_pause, and raises dim after a long user pause.
module pengo_hs_scheduler #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned VB_TIMEOUT = 500000,
    parameter int unsigned DIM_CYC    = 32'h0E4E1C00
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vblank,
    input  logic              user_pause,
    input  logic              hs_req,
    input  logic [ADDR_W-1:0] hs_addr_in,
    input  logic              hs_wr_in,
    output logic              hs_grant,
    output logic [ADDR_W-1:0] hs_addr,
    output logic              hs_wr,
    output logic              core_pause,
    output logic              dim,
    output logic              busy
);

    // state     | meaning
    // S_IDLE    | core runs, RAM owned by the Z80
    // S_WAIT_VB | core paused, waiting for vblank rise or timeout
    // S_SETTLE  | guard band before handing the RAM port over
    // S_GRANT   | hiscore engine owns the RAM port
    // S_RELEASE | guard band before the core resumes
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_VB,
        S_SETTLE,
        S_GRANT,
        S_RELEASE
    } state_t;

    localparam logic [7:0]  ST_LAST  = 8'(SETTLE_CYC - 1);
    localparam logic [19:0] TO_LAST  = 20'(VB_TIMEOUT - 1);
    localparam logic [31:0] DIM_MAX  = 32'(DIM_CYC);

    state_t      r_state;
    logic [7:0]  r_set_cnt;
    logic [19:0] r_to_cnt;
    logic        r_to_hit;
    logic        r_grant;
    logic        r_busy;
    logic        r_vb_q1;
    logic        r_vb_q2;
    logic        r_up_q1;
    logic        r_up_q2;
    logic        r_toggle;
    logic [31:0] r_dim_cnt;
    logic        r_core_pause;

    logic w_vb_rise;
    logic w_up_rise;

    assign w_vb_rise = r_vb_q1 & ~r_vb_q2;
    assign w_up_rise = r_up_q1 & ~r_up_q2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_set_cnt <= '0;
            r_to_cnt  <= '0;
            r_to_hit  <= 1'b0;
            r_grant   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_to_cnt  <= '0;
                    r_to_hit  <= 1'b0;
                    r_set_cnt <= '0;
                    r_grant   <= 1'b0;
                    if (hs_req) begin
                        r_state <= S_WAIT_VB;
                        r_busy  <= 1'b1;
                    end
                end
                S_WAIT_VB: begin
                    if (!hs_req) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_vb_rise || r_to_hit) begin
                        r_state   <= S_SETTLE;
                        r_set_cnt <= '0;
                        r_to_hit  <= 1'b0;
                    end else begin
                        // timeout flag is registered so it lines up with the sampled vblank edge
                        if (r_to_cnt != TO_LAST) begin
                            r_to_cnt <= r_to_cnt + 20'd1;
                        end
                        r_to_hit <= (r_to_cnt == TO_LAST);
                    end
                end
                S_SETTLE: begin
                    if (!hs_req) begin
                        r_state   <= S_RELEASE;
                        r_set_cnt <= '0;
                    end else if (r_set_cnt == ST_LAST) begin
                        r_state <= S_GRANT;
                        r_grant <= 1'b1;
                    end else begin
                        r_set_cnt <= r_set_cnt + 8'd1;
                    end
                end
                S_GRANT: begin
                    if (!hs_req) begin
                        r_state   <= S_RELEASE;
                        r_grant   <= 1'b0;
                        r_set_cnt <= '0;
                    end
                end
                S_RELEASE: begin
                    if (r_set_cnt == ST_LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_set_cnt <= r_set_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vb_q1      <= 1'b0;
            r_vb_q2      <= 1'b0;
            r_up_q1      <= 1'b0;
            r_up_q2      <= 1'b0;
            r_toggle     <= 1'b0;
            r_dim_cnt    <= '0;
            r_core_pause <= 1'b0;
        end else begin
            r_vb_q1      <= vblank;
            r_vb_q2      <= r_vb_q1;
            r_up_q1      <= user_pause;
            r_up_q2      <= r_up_q1;
            r_toggle     <= r_toggle ^ w_up_rise;
            r_core_pause <= r_toggle | (r_state != S_IDLE);
            // only the user pause ages the dim timer
            if (!r_toggle) begin
                r_dim_cnt <= '0;
            end else if (r_dim_cnt != DIM_MAX) begin
                r_dim_cnt <= r_dim_cnt + 32'd1;
            end
        end
    end

    assign hs_grant   = r_grant;
    assign hs_addr    = hs_addr_in;
    assign hs_wr      = hs_wr_in & r_grant;
    assign core_pause = r_core_pause;
    assign dim        = (r_dim_cnt == DIM_MAX);
    assign busy       = r_busy;

endmodule
